// File: rtl/pixel_arb_pkg.sv
// Shared types and widths for the pixel write arbiter.
package pixel_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int GAP_W  = 4;
    localparam int DROP_W = 8;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

endpackage

// File: rtl/pixel_arb_rr.sv
// Two-requester grant selection. Compile-time option PIXEL_ARB_PRIO_EN selects
// strict r0 priority instead of round-robin.
module pixel_arb_rr (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,   // 0: r0 granted most recently, 1: r1
    output logic [1:0] grant
);

`ifdef PIXEL_ARB_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end
`else
    always_comb begin
        grant = {valid1, valid0};
        // On a tie the requester that did not win last time goes first.
        if (valid0 && valid1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule

// File: rtl/pixel_write_arbiter.sv
// Arbitrates two pixel-write requesters onto one LED-controller pixel port,
// enforcing GAP idle cycles after each write. Option: PIXEL_ARB_PRIO_EN.
module pixel_write_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int ASIZE = 6,
    parameter int CSIZE = 8,
    parameter int XMAX  = 63,
    parameter int YMAX  = 63,
    parameter int GAP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ASIZE-1:0]  r0_x,
    input  logic [ASIZE-1:0]  r0_y,
    input  logic [CSIZE-1:0]  r0_color,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ASIZE-1:0]  r1_x,
    input  logic [ASIZE-1:0]  r1_y,
    input  logic [CSIZE-1:0]  r1_color,
    output logic [ASIZE-1:0]  pix_x,
    output logic [ASIZE-1:0]  pix_y,
    output logic [CSIZE-1:0]  pix_color,
    output logic              pix_write,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
    localparam logic [31:0]      X_LIM    = 32'(XMAX);
    localparam logic [31:0]      Y_LIM    = 32'(YMAX);

    state_t            state_reg;
    state_t            state_next;
    logic [GAP_W-1:0]  gap_reg;
    logic [GAP_W-1:0]  gap_next;
    logic              last_grant_reg;
    logic [1:0]        grant;
    logic              idle;
    logic              accept;
    logic              in_range;
    logic              write_go;
    logic              drop_go;
    logic [ASIZE-1:0]  sel_x;
    logic [ASIZE-1:0]  sel_y;
    logic [CSIZE-1:0]  sel_color;

    pixel_arb_rr u_rr (
        .valid0     (r0_valid),
        .valid1     (r1_valid),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    assign idle      = (state_reg == IDLE);
    assign sel_x     = grant[1] ? r1_x     : r0_x;
    assign sel_y     = grant[1] ? r1_y     : r0_y;
    assign sel_color = grant[1] ? r1_color : r0_color;

    // Coordinates are widened so the bound check stays correct even when
    // XMAX/YMAX do not fit in ASIZE bits.
    assign in_range = ({{(32-ASIZE){1'b0}}, sel_x} <= X_LIM) &&
                      ({{(32-ASIZE){1'b0}}, sel_y} <= Y_LIM);
    assign accept   = idle && (grant != 2'b00);
    assign write_go = accept && in_range;
    assign drop_go  = accept && !in_range;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        case (state_reg)
            IDLE: begin
                if (write_go) begin
                    state_next = WAIT;
                    gap_next   = GAP_LOAD;
                end
            end
            WAIT: begin
                if (gap_reg != '0) begin
                    gap_next = gap_reg - 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                gap_next   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        r0_ready = idle && grant[0];
        r1_ready = idle && grant[1];
        busy     = !idle;
    end

    // Pixel port, grant pointer and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_write      <= 1'b0;
            pix_x          <= '0;
            pix_y          <= '0;
            pix_color      <= '0;
            last_grant_reg <= 1'b1;
            drop_cnt       <= '0;
        end else begin
            pix_write <= write_go;
            if (write_go) begin
                pix_x          <= sel_x;
                pix_y          <= sel_y;
                pix_color      <= sel_color;
                last_grant_reg <= grant[1];
            end
            if (drop_go && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: a timeline model checked every
// cycle, plus literal checks of the headline scenarios.
module tb_pixel_write_arbiter;

    localparam int AS = 7;
    localparam int CS = 8;
    localparam int XM = 63;
    localparam int YM = 63;
    localparam int GP = 2;

    typedef struct packed {
        logic [AS-1:0] x;
        logic [AS-1:0] y;
        logic [CS-1:0] c;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_valid, r1_valid, r0_ready, r1_ready;
    logic [AS-1:0] r0_x, r0_y, r1_x, r1_y, pix_x, pix_y;
    logic [CS-1:0] r0_color, r1_color, pix_color;
    logic          pix_write, busy;
    logic [7:0]    drop_cnt;

    logic          g_valid, g_ready, g_r1_ready, g_pix_write, g_busy;
    logic          g_r1_valid;
    logic [AS-1:0] g_x, g_y, g_r1_x, g_r1_y, g_pix_x, g_pix_y;
    logic [CS-1:0] g_color, g_r1_color, g_pix_color;
    logic [7:0]    g_drop_cnt;

    always #5 clk = ~clk;

    pixel_write_arbiter #(.ASIZE(AS), .CSIZE(CS), .XMAX(XM), .YMAX(YM), .GAP(GP)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_x(r0_x), .r0_y(r0_y), .r0_color(r0_color),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_x(r1_x), .r1_y(r1_y), .r1_color(r1_color),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_write(pix_write),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    pixel_write_arbiter #(.ASIZE(AS), .CSIZE(CS), .XMAX(XM), .YMAX(YM), .GAP(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(g_valid), .r0_ready(g_ready), .r0_x(g_x), .r0_y(g_y), .r0_color(g_color),
        .r1_valid(g_r1_valid), .r1_ready(g_r1_ready), .r1_x(g_r1_x), .r1_y(g_r1_y), .r1_color(g_r1_color),
        .pix_x(g_pix_x), .pix_y(g_pix_y), .pix_color(g_pix_color), .pix_write(g_pix_write),
        .busy(g_busy), .drop_cnt(g_drop_cnt)
    );

    int   checks = 0;
    int   errors = 0;
    req_t q0[$];
    req_t q1[$];
    int   gl[$];      // requester of each in-range grant
    int   gc[$];      // cycle of each in-range grant
    req_t wl[$];      // pixels seen on the port

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int   cyc, idle_from, exp_drop;
    bit   prefer1, exp_wr, acc0, acc1, m_idle, p0, p1, inr;
    req_t exp_pix, pl;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0; idle_from = 0; prefer1 = 1'b0; exp_wr = 1'b0;
            exp_pix = '0; exp_drop = 0; acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            m_idle = (cyc >= idle_from);
`ifdef PIXEL_ARB_PRIO_EN
            p0 = r0_valid;
            p1 = r1_valid && !r0_valid;
`else
            p0 = r0_valid && (!r1_valid || !prefer1);
            p1 = r1_valid && (!r0_valid || prefer1);
`endif
            p0 = p0 && m_idle;
            p1 = p1 && m_idle;
            chk("r0_ready", r0_ready, p0);
            chk("r1_ready", r1_ready, p1);
            chk("busy", busy, !m_idle);
            chk("pix_write", pix_write, exp_wr);
            chk("pix_x", pix_x, exp_pix.x);
            chk("pix_y", pix_y, exp_pix.y);
            chk("pix_color", pix_color, exp_pix.c);
            chk("drop_cnt", drop_cnt, exp_drop);
            if (pix_write) wl.push_back({pix_x, pix_y, pix_color});
            exp_wr = 1'b0;
            if (p0 || p1) begin
                pl  = p0 ? req_t'({r0_x, r0_y, r0_color}) : req_t'({r1_x, r1_y, r1_color});
                inr = (int'(pl.x) <= XM) && (int'(pl.y) <= YM);
                $display("t=%0t grant r%0d x=%0d y=%0d color=%02h %s",
                         $time, p0 ? 0 : 1, pl.x, pl.y, pl.c, inr ? "write" : "drop");
                if (inr) begin
                    exp_wr    = 1'b1;
                    exp_pix   = pl;
                    idle_from = cyc + GP + 2;
                    prefer1   = p0;
                    gl.push_back(p0 ? 0 : 1);
                    gc.push_back(cyc);
                end else if (exp_drop < 255) begin
                    exp_drop++;
                end
            end
            acc0 = r0_valid && r0_ready;
            acc1 = r1_valid && r1_ready;
            cyc++;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive();
        r0_valid = (q0.size() > 0);
        r1_valid = (q1.size() > 0);
        if (q0.size() > 0) {r0_x, r0_y, r0_color} = q0[0];
        if (q1.size() > 0) {r1_x, r1_y, r1_color} = q1[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d requests left, required 0", q0.size() + q1.size());
        end
        repeat (GP + 3) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int   exp_order[4];
    req_t tbl0[5];
    req_t tbl1[5];
    int   n;
    bit   g_exp;

    initial begin
        r0_x = '0; r0_y = '0; r0_color = '0; r1_x = '0; r1_y = '0; r1_color = '0;
        r0_valid = 1'b0; r1_valid = 1'b0;
        g_valid = 1'b0; g_x = 7'd1; g_y = 7'd2; g_color = 8'h33;
        g_r1_valid = 1'b0; g_r1_x = '0; g_r1_y = '0; g_r1_color = '0;
        do_reset();

        // reset state
        @(negedge clk);
        #1;
        chk("reset_pix_write", pix_write, 0);
        chk("reset_busy", busy, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        chk("reset_pix_color", pix_color, 0);

        // single r0 write, then a second one spaced GAP+2 cycles later
        wl.delete(); gl.delete(); gc.delete();
        q0.push_back('{x: 7'd5, y: 7'd7, c: 8'hA5});
        q0.push_back('{x: 7'd6, y: 7'd8, c: 8'h5A});
        step();
        drain(40);
        chk("single_writes", wl.size(), 2);
        if (wl.size() >= 1) chk("single_pixel", wl[0], {7'd5, 7'd7, 8'hA5});
        if (gc.size() >= 2) chk("single_spacing", gc[1] - gc[0], 4);

        // both valid continuously: grant order
        do_reset();
        gl.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{x: 7'(i), y: 7'd1, c: 8'(8'h10 + i)});
            q1.push_back('{x: 7'(i), y: 7'd2, c: 8'(8'h20 + i)});
        end
        step();
        drain(100);
`ifdef PIXEL_ARB_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        chk("order_count", gl.size(), 8);
        for (int i = 0; i < 4 && i < gl.size(); i++) chk($sformatf("order_%0d", i), gl[i], exp_order[i]);

        // out-of-range requests: accepted, dropped, counter saturates
        do_reset();
        q1.push_back('{x: 7'd64, y: 7'd0, c: 8'h11});
        step();
        drain(20);
        chk("drop_one", drop_cnt, 1);
        for (int i = 0; i < 300; i++) q1.push_back('{x: 7'd100, y: 7'(i % 64), c: 8'(i)});
        step();
        drain(400);
        chk("drop_saturate", drop_cnt, 255);
        gl.delete();
        q0.push_back('{x: 7'd1, y: 7'd1, c: 8'h01});
        q1.push_back('{x: 7'd2, y: 7'd2, c: 8'h02});
        step();
        drain(40);
        if (gl.size() >= 1) chk("tie_after_drops", gl[0], 0);

        // mixed boundary table, including a valid raised while busy
        tbl0 = '{'{7'd63, 7'd63, 8'hFF}, '{7'd63, 7'd64, 8'h33}, '{7'd0, 7'd0, 8'h00},
                 '{7'd64, 7'd63, 8'h44}, '{7'd31, 7'd17, 8'hC3}};
        tbl1 = '{'{7'd10, 7'd63, 8'h22}, '{7'd0, 7'd0, 8'h44}, '{7'd127, 7'd127, 8'h55},
                 '{7'd62, 7'd1, 8'h66}, '{7'd5, 7'd5, 8'h77}};
        q0.push_back(tbl0[0]);
        step();
        step();
        for (int i = 0; i < 5; i++) q1.push_back(tbl1[i]);
        for (int i = 1; i < 5; i++) q0.push_back(tbl0[i]);
        drive();
        drain(100);

        // reset asserted during a strobe cycle
        do_reset();
        q0.push_back('{x: 7'd9, y: 7'd9, c: 8'h5A});
        drive();
        n = 0;
        while (!pix_write && n < 20) begin
            step();
            n++;
        end
        chk("strobe_seen", pix_write, 1);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        #1;
        chk("async_kill_write", pix_write, 0);
        chk("async_kill_x", pix_x, 0);
        chk("async_kill_color", pix_color, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gl.delete();
        wl.delete();
        repeat (3) step();
        chk("no_replay", wl.size(), 0);
        q0.push_back('{x: 7'd3, y: 7'd4, c: 8'hAB});
        q1.push_back('{x: 7'd4, y: 7'd3, c: 8'hBA});
        drive();
        drain(40);
        if (gl.size() >= 1) chk("tie_after_reset", gl[0], 0);

        // GAP=0 instance: continuous r0 gives a 1,0,1,0 strobe
        @(posedge clk);
        #1;
        g_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!g_pix_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            g_exp = (i % 2 == 0);
            chk($sformatf("gap0_toggle_%0d", i), g_pix_write, g_exp);
            if (i < 3) @(negedge clk);
        end
        chk("gap0_pixel", {g_pix_x, g_pix_y, g_pix_color}, {7'd1, 7'd2, 8'h33});
        g_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
